uart_receiver: RTL and testbench

Serial-to-parallel UART receiver: the receive end of the team's 8-bit UART link, the counterpart of the existing transmitter. It synchronises the asynchronous `iRx` line, detects and validates the start bit, and samples each bit at mid-bit using an internal baud counter. It delivers one byte per frame with a single-cycle valid strobe plus parity and framing status. It sits between the board RX pin and the byte consumer (FIFO or command decoder).

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_receiver.sv | 129 ++++++++++++
 tb/tb_uart_receiver.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8-bit UART link (receiver and transmitter).
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLK_HZ           = 50_000_000;
    localparam int BAUD_RATE        = 115_200;
    localparam int CLKS_PER_BIT_DEF = CLK_HZ / BAUD_RATE;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iD,
    output logic oQ
);

    logic meta;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            meta <= RST_VAL;
            oQ   <= RST_VAL;
        end else begin
            meta <= iD;
            oQ   <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start-bit validation, mid-bit sampling, optional parity,
// framing check and break handling; one-cycle oValid per frame.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iRx,
    output logic [DATA_BITS-1:0] oData,
    output logic                 oValid,
    output logic                 oParityErr,
    output logic                 oFrameErr,
    output logic                 oBusy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err;
    logic                 tick;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iD     (iRx),
        .oQ     (rx_s)
    );

    assign tick = (baud_cnt == '0);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_err    <= 1'b0;
            oData      <= '0;
            oValid     <= 1'b0;
            oParityErr <= 1'b0;
            oFrameErr  <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (state != IDLE && !tick)
                baud_cnt <= baud_cnt - CNT_ONE;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        bit_cnt  <= '0;
                        baud_cnt <= HALF_RELOAD;
                        par_err  <= 1'b0;
                        state    <= START;
                        oBusy    <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        // A line that is high again at mid-start-bit was a glitch.
                        if (rx_s) begin
                            state <= IDLE;
                            oBusy <= 1'b0;
                        end else begin
                            baud_cnt <= FULL_RELOAD;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift    <= {rx_s, shift[DATA_BITS-1:1]};
                        baud_cnt <= FULL_RELOAD;
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) state <= PARITY;
                            else                state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        par_err  <= ((^shift) ^ rx_s) != (PARITY_ODD != 0);
                        baud_cnt <= FULL_RELOAD;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        oValid     <= 1'b1;
                        oData      <= shift;
                        oParityErr <= par_err;
                        oFrameErr  <= !rx_s;
                        // Returning to IDLE at mid-stop lets a back-to-back start edge in.
                        if (rx_s) begin
                            state <= IDLE;
                            oBusy <= 1'b0;
                        end else begin
                            state <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        oBusy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit, even parity.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       iClk;
    logic       iRst_n;
    logic       iRx;
    logic [7:0] oData;
    logic       oValid;
    logic       oParityErr;
    logic       oFrameErr;
    logic       oBusy;

    int         cyc;
    int         vcount;
    int         vcyc;
    logic [7:0] cap_data [0:63];
    int         errors;
    int         checks;

    uart_receiver #(
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (1),
        .PARITY_ODD   (0)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iRx        (iRx),
        .oData      (oData),
        .oValid     (oValid),
        .oParityErr (oParityErr),
        .oFrameErr  (oFrameErr),
        .oBusy      (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // Record every strobe away from the active edge.
    initial vcount = 0;
    always @(negedge iClk) begin
        if (oValid === 1'b1) begin
            if (vcount < 64) cap_data[vcount] = oData;
            vcyc   = cyc;
            vcount = vcount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        iRx = b;
        repeat (CPB) @(posedge iClk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(stop);
    endtask

    int t0;
    int vc0;

    initial begin
        errors = 0;
        checks = 0;
        iRst_n = 1'b0;
        iRx    = 1'b1;

        // Reset with a toggling line
        for (int i = 0; i < 10; i++) begin
            @(posedge iClk); #1;
            iRx = ~iRx;
        end
        #2;
        chk("rst_data",  32'(oData), 32'h00);
        chk("rst_valid", 32'(oValid), 32'h0);
        chk("rst_perr",  32'(oParityErr), 32'h0);
        chk("rst_ferr",  32'(oFrameErr), 32'h0);
        chk("rst_busy",  32'(oBusy), 32'h0);
        @(posedge iClk); #1;
        iRx    = 1'b1;
        iRst_n = 1'b1;
        repeat (40) @(posedge iClk);
        #1;
        chk("rel_novalid", 32'(vcount), 32'd0);
        chk("rel_busy",    32'(oBusy), 32'h0);

        // Clean frame A5, even parity bit 0
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        chk("a5_count",   32'(vcount), 32'd1);
        chk("a5_latency", 32'(vcyc - t0), 32'd171);
        chk("a5_data",    32'(oData), 32'hA5);
        chk("a5_perr",    32'(oParityErr), 32'h0);
        chk("a5_ferr",    32'(oFrameErr), 32'h0);
        chk("a5_busy",    32'(oBusy), 32'h0);

        // Parity error on 01, then cleared by a good 3C
        send_frame(8'h01, 1'b0, 1'b1);
        chk("p01_count", 32'(vcount), 32'd2);
        chk("p01_data",  32'(oData), 32'h01);
        chk("p01_perr",  32'(oParityErr), 32'h1);
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("p3c_count", 32'(vcount), 32'd3);
        chk("p3c_data",  32'(oData), 32'h3C);
        chk("p3c_perr",  32'(oParityErr), 32'h0);

        // Framing error followed by a 40-bit break
        send_frame(8'h7E, 1'b0, 1'b0);
        repeat (40 * CPB) @(posedge iClk);
        #1;
        chk("brk_count", 32'(vcount), 32'd4);
        chk("brk_data",  32'(oData), 32'h7E);
        chk("brk_ferr",  32'(oFrameErr), 32'h1);
        chk("brk_perr",  32'(oParityErr), 32'h0);
        chk("brk_busy",  32'(oBusy), 32'h1);
        iRx = 1'b1;
        repeat (5) @(posedge iClk);
        #1;
        chk("brk_idle",  32'(oBusy), 32'h0);
        repeat (3 * CPB) @(posedge iClk);
        #1;
        chk("brk_nomore", 32'(vcount), 32'd4);

        // Start glitch of 5 cycles
        iRx = 1'b0;
        repeat (5) @(posedge iClk);
        #1;
        chk("gl_busy_hi", 32'(oBusy), 32'h1);
        iRx = 1'b1;
        repeat (7) @(posedge iClk);
        #1;
        chk("gl_busy_lo", 32'(oBusy), 32'h0);
        repeat (2 * CPB) @(posedge iClk);
        #1;
        chk("gl_novalid", 32'(vcount), 32'd4);

        // Back-to-back frames
        vc0 = vcount;
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        chk("b2b_count", 32'(vcount - vc0), 32'd3);
        chk("b2b_d0",    32'(cap_data[vc0]), 32'h00);
        chk("b2b_d1",    32'(cap_data[vc0 + 1]), 32'hFF);
        chk("b2b_d2",    32'(cap_data[vc0 + 2]), 32'h55);
        chk("b2b_perr",  32'(oParityErr), 32'h0);

        // Reset during bit 4 of a 99 frame
        vc0 = vcount;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1 & (8'h99 >> i));
        iRx = 1'b1;
        repeat (CPB / 2) @(posedge iClk);
        #1;
        iRst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(oBusy), 32'h0);
        chk("mid_rst_data", 32'(oData), 32'h00);
        repeat (3) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        repeat (12 * CPB) @(posedge iClk);
        #1;
        chk("mid_rst_novalid", 32'(vcount - vc0), 32'd0);
        send_frame(8'hC3, 1'b0, 1'b1);
        chk("c3_count", 32'(vcount - vc0), 32'd1);
        chk("c3_data",  32'(oData), 32'hC3);
        chk("c3_perr",  32'(oParityErr), 32'h0);
        chk("c3_ferr",  32'(oFrameErr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
